// File: rtl/nf10_output_demux.sv
// rtl/nf10_output_demux.sv - fans one merged AXI4-Stream out to 5 ports by the first-beat tuser mask.
// Optional drop counter: define NF10_OUTPUT_DEMUX_DROP_COUNT_EN.
module nf10_output_demux #(
   parameter int C_AXIS_DATA_WIDTH = 64,
   parameter int C_USER_WIDTH      = 128,
   parameter int C_DST_POS         = 24
) (
   input  logic                           axi_aclk,
   input  logic                           axi_reset,
   input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic [C_USER_WIDTH-1:0]        s_axis_tuser,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata_0,
   output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb_0,
   output logic [C_USER_WIDTH-1:0]        m_axis_tuser_0,
   output logic                           m_axis_tvalid_0,
   input  logic                           m_axis_tready_0,
   output logic                           m_axis_tlast_0,
   output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata_1,
   output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb_1,
   output logic [C_USER_WIDTH-1:0]        m_axis_tuser_1,
   output logic                           m_axis_tvalid_1,
   input  logic                           m_axis_tready_1,
   output logic                           m_axis_tlast_1,
   output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata_2,
   output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb_2,
   output logic [C_USER_WIDTH-1:0]        m_axis_tuser_2,
   output logic                           m_axis_tvalid_2,
   input  logic                           m_axis_tready_2,
   output logic                           m_axis_tlast_2,
   output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata_3,
   output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb_3,
   output logic [C_USER_WIDTH-1:0]        m_axis_tuser_3,
   output logic                           m_axis_tvalid_3,
   input  logic                           m_axis_tready_3,
   output logic                           m_axis_tlast_3,
   output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata_4,
   output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb_4,
   output logic [C_USER_WIDTH-1:0]        m_axis_tuser_4,
   output logic                           m_axis_tvalid_4,
   input  logic                           m_axis_tready_4,
   output logic                           m_axis_tlast_4,
   output logic [31:0]                    drop_count
);

   localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

   typedef enum logic {ST_SOP, ST_MID} state_t;

   state_t                       state;
   logic [4:0]                   dest;
   logic [4:0]                   pend;
   logic [C_AXIS_DATA_WIDTH-1:0] hold_data;
   logic [STRB_W-1:0]            hold_strb;
   logic [C_USER_WIDTH-1:0]      hold_user;
   logic                         hold_last;

   logic [4:0] ready_vec;
   logic [4:0] live_mask;
   logic [4:0] mask_eff;
   logic       accept;

   assign ready_vec = {m_axis_tready_4, m_axis_tready_3, m_axis_tready_2,
                       m_axis_tready_1, m_axis_tready_0};
   assign live_mask = s_axis_tuser[C_DST_POS +: 5];
   assign mask_eff  = (state == ST_SOP) ? live_mask : dest;

   // Ready as soon as every still-pending copy is being taken this cycle,
   // so the holding register refills in the same cycle it drains.
   assign s_axis_tready = ((pend & ~ready_vec) == 5'd0);
   assign accept        = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state     <= ST_SOP;
         dest      <= 5'd0;
         pend      <= 5'd0;
         hold_data <= '0;
         hold_strb <= '0;
         hold_user <= '0;
         hold_last <= 1'b0;
      end else if (accept) begin
         hold_data <= s_axis_tdata;
         hold_strb <= s_axis_tstrb;
         hold_user <= s_axis_tuser;
         hold_last <= s_axis_tlast;
         pend      <= mask_eff;
         case (state)
            ST_SOP: begin
               dest  <= live_mask;
               state <= s_axis_tlast ? ST_SOP : ST_MID;
            end
            ST_MID: begin
               if (s_axis_tlast) state <= ST_SOP;
            end
            default: state <= ST_SOP;
         endcase
      end else begin
         pend <= pend & ~ready_vec;
      end
   end

`ifdef NF10_OUTPUT_DEMUX_DROP_COUNT_EN
   logic [31:0] drop_cnt;

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         drop_cnt <= 32'd0;
      end else if (accept && state == ST_SOP && live_mask == 5'd0 &&
                   drop_cnt != 32'hFFFF_FFFF) begin
         drop_cnt <= drop_cnt + 32'd1;
      end
   end

   assign drop_count = drop_cnt;
`else
   assign drop_count = 32'd0;
`endif

   assign m_axis_tdata_0  = hold_data;
   assign m_axis_tstrb_0  = hold_strb;
   assign m_axis_tuser_0  = hold_user;
   assign m_axis_tlast_0  = hold_last;
   assign m_axis_tvalid_0 = pend[0];

   assign m_axis_tdata_1  = hold_data;
   assign m_axis_tstrb_1  = hold_strb;
   assign m_axis_tuser_1  = hold_user;
   assign m_axis_tlast_1  = hold_last;
   assign m_axis_tvalid_1 = pend[1];

   assign m_axis_tdata_2  = hold_data;
   assign m_axis_tstrb_2  = hold_strb;
   assign m_axis_tuser_2  = hold_user;
   assign m_axis_tlast_2  = hold_last;
   assign m_axis_tvalid_2 = pend[2];

   assign m_axis_tdata_3  = hold_data;
   assign m_axis_tstrb_3  = hold_strb;
   assign m_axis_tuser_3  = hold_user;
   assign m_axis_tlast_3  = hold_last;
   assign m_axis_tvalid_3 = pend[3];

   assign m_axis_tdata_4  = hold_data;
   assign m_axis_tstrb_4  = hold_strb;
   assign m_axis_tuser_4  = hold_user;
   assign m_axis_tlast_4  = hold_last;
   assign m_axis_tvalid_4 = pend[4];

endmodule

// File: tb/tb_nf10_output_demux.sv
// tb/tb_nf10_output_demux.sv - scoreboard bench for nf10_output_demux.
module tb_nf10_output_demux;

   typedef struct packed {
      logic [63:0]  d;
      logic [7:0]   s;
      logic [127:0] u;
      logic         l;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [63:0]  s_tdata;
   logic [7:0]   s_tstrb;
   logic [127:0] s_tuser;
   logic         s_tvalid;
   logic         s_tready;
   logic         s_tlast;
   logic [63:0]  m_tdata [5];
   logic [7:0]   m_tstrb [5];
   logic [127:0] m_tuser [5];
   logic [4:0]   m_tvalid;
   logic [4:0]   m_tready;
   logic [4:0]   m_tlast;
   logic [31:0]  drop_count;

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   bit    toggle4 = 1'b0;

   // reference model state
   beat_t      sb [5][$];
   logic [4:0] mp = 5'd0;
   logic [4:0] dmask = 5'd0;
   bit         first = 1'b1;
   int         exp_drops = 0;

   always #5 clk = ~clk;

   nf10_output_demux dut (
      .axi_aclk(clk), .axi_reset(rst),
      .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata_0(m_tdata[0]), .m_axis_tstrb_0(m_tstrb[0]), .m_axis_tuser_0(m_tuser[0]),
      .m_axis_tvalid_0(m_tvalid[0]), .m_axis_tready_0(m_tready[0]), .m_axis_tlast_0(m_tlast[0]),
      .m_axis_tdata_1(m_tdata[1]), .m_axis_tstrb_1(m_tstrb[1]), .m_axis_tuser_1(m_tuser[1]),
      .m_axis_tvalid_1(m_tvalid[1]), .m_axis_tready_1(m_tready[1]), .m_axis_tlast_1(m_tlast[1]),
      .m_axis_tdata_2(m_tdata[2]), .m_axis_tstrb_2(m_tstrb[2]), .m_axis_tuser_2(m_tuser[2]),
      .m_axis_tvalid_2(m_tvalid[2]), .m_axis_tready_2(m_tready[2]), .m_axis_tlast_2(m_tlast[2]),
      .m_axis_tdata_3(m_tdata[3]), .m_axis_tstrb_3(m_tstrb[3]), .m_axis_tuser_3(m_tuser[3]),
      .m_axis_tvalid_3(m_tvalid[3]), .m_axis_tready_3(m_tready[3]), .m_axis_tlast_3(m_tlast[3]),
      .m_axis_tdata_4(m_tdata[4]), .m_axis_tstrb_4(m_tstrb[4]), .m_axis_tuser_4(m_tuser[4]),
      .m_axis_tvalid_4(m_tvalid[4]), .m_axis_tready_4(m_tready[4]), .m_axis_tlast_4(m_tlast[4]),
      .drop_count(drop_count)
   );

   function automatic logic [127:0] mk_user(input logic [4:0] mask);
      logic [127:0] u;
      u = {$urandom, $urandom, $urandom, $urandom};
      u[28:24] = mask;
      return u;
   endfunction

   // One clock: check outputs against the model at negedge, advance the model,
   // then return just after the next posedge.
   task automatic cycle(output bit acc);
      logic       exp_rdy;
      logic [4:0] mask;
      beat_t      got;
      beat_t      exp;
      beat_t      inb;
      @(negedge clk);
      exp_rdy = ((mp & ~m_tready) == 5'd0);
      checks++;
      assert (m_tvalid === mp) else begin
         failures++;
         $error("FAIL tvalid got=%b exp=%b cyc=%0d", m_tvalid, mp, cyc);
      end
      checks++;
      assert (s_tready === exp_rdy) else begin
         failures++;
         $error("FAIL s_tready got=%b exp=%b cyc=%0d", s_tready, exp_rdy, cyc);
      end
      for (int n = 0; n < 5; n++) begin
         if (mp[n] && m_tready[n]) begin
            got = '{d: m_tdata[n], s: m_tstrb[n], u: m_tuser[n], l: m_tlast[n]};
            checks++;
            if (sb[n].size() == 0) begin
               failures++;
               $error("FAIL port%0d_extra got=%h exp=none", n, got.d);
            end else begin
               exp = sb[n].pop_front();
               assert (got === exp) else begin
                  failures++;
                  $error("FAIL port%0d_beat got=%h/%b exp=%h/%b", n, got.d, got.l, exp.d, exp.l);
               end
            end
         end
      end
      acc = !rst && s_tvalid && exp_rdy;
      if (rst) begin
         mp    = 5'd0;
         first = 1'b1;
         for (int n = 0; n < 5; n++) sb[n].delete();
      end else if (acc) begin
         mask = first ? s_tuser[28:24] : dmask;
         if (first) begin
            dmask = s_tuser[28:24];
            if (mask == 5'd0) exp_drops++;
         end
         inb = '{d: s_tdata, s: s_tstrb, u: s_tuser, l: s_tlast};
         for (int n = 0; n < 5; n++) if (mask[n]) sb[n].push_back(inb);
         mp    = mask;
         first = s_tlast;
      end else begin
         mp = mp & ~m_tready;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (toggle4) m_tready[4] = ~m_tready[4];
   endtask

   task automatic idle(input int n);
      bit acc;
      s_tvalid = 1'b0;
      for (int i = 0; i < n; i++) cycle(acc);
   endtask

   task automatic send(input logic [4:0] mask, input logic last);
      bit acc;
      int waited;
      s_tdata  = {$urandom, $urandom};
      s_tstrb  = 8'($urandom);
      s_tuser  = mk_user(mask);
      s_tlast  = last;
      s_tvalid = 1'b1;
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 20) begin
         cycle(acc);
         waited++;
      end
      checks++;
      assert (acc) else begin
         failures++;
         $error("FAIL accept_timeout got=0 exp=1 waited=%0d", waited);
      end
   endtask

   task automatic check_drops(input string tag);
      int exp_dc;
`ifdef NF10_OUTPUT_DEMUX_DROP_COUNT_EN
      exp_dc = exp_drops;
`else
      exp_dc = 0;
`endif
      checks++;
      assert (drop_count === 32'(exp_dc)) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, drop_count, exp_dc);
      end
   endtask

   initial begin
      int start_cyc;
      rst      = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tstrb  = '0;
      s_tuser  = '0;
      s_tlast  = 1'b0;
      m_tready = 5'b11111;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      assert (m_tdata[2] === 64'd0 && m_tuser[4] === 128'd0 && m_tlast === 5'd0) else begin
         failures++;
         $error("FAIL reset_hold got=%h exp=0", m_tdata[2]);
      end
      check_drops("reset_drop_count");
      @(posedge clk);
      #1;

      // unicast
      for (int i = 0; i < 4; i++) send(5'b00100, i == 3);
      idle(3);

      // multicast with port 4 backpressure
      toggle4 = 1'b1;
      for (int i = 0; i < 3; i++) send(5'b10001, i == 2);
      idle(6);
      toggle4 = 1'b0;
      m_tready[4] = 1'b1;
      idle(2);

      // mask taken from the first beat only
      send(5'b00010, 1'b0);
      send(5'b01000, 1'b1);
      idle(3);

      // drop then unicast
      for (int i = 0; i < 5; i++) send(5'b00000, i == 4);
      send(5'b00001, 1'b1);
      idle(3);
      check_drops("drop_count");

      // back-to-back single-beat packets
      start_cyc = cyc;
      for (int i = 0; i < 40; i++) send(5'(1 << (i % 5)), 1'b1);
      checks++;
      assert (cyc - start_cyc == 40) else begin
         failures++;
         $error("FAIL b2b_cycles got=%0d exp=40", cyc - start_cyc);
      end
      idle(3);

      // reset in the middle of a packet
      send(5'b01000, 1'b0);
      send(5'b01000, 1'b0);
      s_tvalid = 1'b0;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      assert (m_tvalid === 5'd0 && m_tdata[3] === 64'd0) else begin
         failures++;
         $error("FAIL midreset_clear got=%b/%h exp=0/0", m_tvalid, m_tdata[3]);
      end
      @(posedge clk);
      #1;
      send(5'b00001, 1'b1);
      idle(3);
      check_drops("final_drop_count");

      for (int n = 0; n < 5; n++) begin
         checks++;
         assert (sb[n].size() == 0) else begin
            failures++;
            $error("FAIL port%0d_leftover got=%0d exp=0", n, sb[n].size());
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nf10_output_demux.md
Name: nf10_output_demux

Overview:
- Other end of the input arbiter: takes the single merged AXI4-Stream and fans each packet out to up to 5 output streams.
- Destination is the one-hot port mask carried in the first beat's tuser.
- Sits between output-port lookup and the per-port output queues.
- Supports unicast, multicast (several mask bits set) and drop (mask zero).

Parameters:
C_AXIS_DATA_WIDTH, 64, tdata width on all streams; tstrb is C_AXIS_DATA_WIDTH/8.
C_USER_WIDTH, 128, tuser width on all streams.
C_DST_POS, 24, LSB of the 5-bit destination mask inside tuser (mask = tuser[C_DST_POS+4:C_DST_POS]).

Ports:
axi_aclk  in  1  clock
axi_reset  in  1  synchronous active-high reset
s_axis_tdata  in  C_AXIS_DATA_WIDTH  input data
s_axis_tstrb  in  C_AXIS_DATA_WIDTH/8  byte strobes
s_axis_tuser  in  C_USER_WIDTH  metadata; mask valid on first beat only
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of packet
m_axis_tdata_N  out  C_AXIS_DATA_WIDTH  N=0..4, copy of held beat
m_axis_tstrb_N  out  C_AXIS_DATA_WIDTH/8  N=0..4
m_axis_tuser_N  out  C_USER_WIDTH  N=0..4, tuser of held beat, unmodified
m_axis_tvalid_N  out  1  N=0..4
m_axis_tready_N  in  1  N=0..4
m_axis_tlast_N  out  1  N=0..4
drop_count  out  32  packets dropped for empty mask (see Optional Feature)

Behaviour:
- Single-clock design on axi_aclk. Reset is synchronous, active-high, on axi_reset.
- Storage is one holding register H (data, strb, user, last) plus a 5-bit pending mask P. All m_axis_*_N data buses are driven from H.
- Output valid: m_axis_tvalid_N = P[N]. It is registered and never depends on any tready.
- Output handshake: when P[N] & m_axis_tready_N, clear P[N] next cycle unless H is reloaded.
- Input ready: s_axis_tready = ((P & ~m_axis_tready_vec) == 0). H accepts a new beat in the same cycle its last pending copies drain, giving 1 beat/cycle throughput.
- Latency: beat accepted at cycle t is valid at the outputs at t+1.
- State machine, 2 states:
  - SOP (reset state): on accepted beat, latch dest mask D = tuser[C_DST_POS +: 5].
    - tlast=0: go to MID.
    - tlast=1: stay in SOP (single-beat packet).
  - MID: accepted beats use the stored D; go to SOP on accepted tlast beat.
  - The tuser mask on non-first beats is ignored.
- Load: an accepted beat sets H and sets P = mask in effect (the latched D, or on the first beat the live mask).
- Drop: if the mask in effect is 0, the beat is consumed (tready as above), P stays 0 and nothing is emitted.
- Multicast: all selected ports see identical beats. Each port drains independently; no new beat is loaded until every selected port has taken the current one. Ports never reorder beats.
- Reset values: P=0 (all m_axis_tvalid_N=0), H=0 (all m_axis data/strb/user/last outputs 0), state=SOP, drop_count=0.
- s_axis_tready during reset: combinationally 1 (P=0), but no beat is stored.
- Reset mid-packet: the partial packet is abandoned with no tlast emitted. The next accepted beat is treated as a first beat.
- Input tvalid low: H and P are unchanged except for output drains.

Optional Feature:
- Macro: NF10_OUTPUT_DEMUX_DROP_COUNT_EN.
- When defined: drop_count is a 32-bit counter, incremented by 1 on each accepted first beat whose mask is 0. It saturates at 0xFFFFFFFF and does not wrap.
- When not defined: drop_count is tied to 0 and no counter logic is generated.

Test Plan:
- Unicast: 4-beat packet, mask 5'b00100, all tready=1 -> m_axis_tvalid_2 high cycles t+1..t+4, tlast_2 on 4th beat, other ports' tvalid stay 0, s_axis_tready constant 1.
- Multicast backpressure: 3-beat packet, mask 5'b10001, tready_0=1 and tready_4 toggling 1/0 -> port 0 takes each beat once, identical beat sequences on ports 0 and 4, s_axis_tready low while P[4] pending, no beat lost or duplicated.
- Mask only on first beat: 2-beat packet, first beat mask 5'b00010, second beat tuser mask 5'b01000 -> both beats appear on port 1 only.
- Drop: 5-beat packet with mask 0, then 1-beat packet mask 5'b00001 -> no output valid for the first packet; second beat on port 0 one cycle after acceptance; drop_count=1 with macro defined, 0 without.
- Back-to-back: 40 single-beat packets cycling masks 1,2,4,8,16 with all tready=1 -> one output beat per cycle, tlast on every beat, correct port each time.
- Reset mid-packet: assert axi_reset for 1 cycle after beat 2 of a 6-beat packet to port 3 -> all tvalid 0 and state SOP next cycle; the following packet with mask 5'b00001 routes to port 0.
